// File: rtl/pe_array_stu_arbiter.sv
// Upstream stack-bus arbiter: collects result packets from every PE,
// grants one packet at a time in round-robin order and serialises the
// beats, tagged with their source PE id, through a 2-entry output FIFO.

// Per-PE request qualification: a PE may open a packet only with a
// start beat (SOM / SOM_EOM). Any other valid beat seen while nobody
// holds a grant is stray.
module pe_array_stu_lane (
    input  logic       valid,
    input  logic [1:0] cntl,
    output logic       eligible,
    output logic       stray
);
    // cntl[0] marks a start-of-message beat, cntl[1] an end-of-message beat
    assign eligible = valid &  cntl[0];
    assign stray    = valid & ~cntl[0];
endmodule

module pe_array_stu_arbiter #(
    parameter int NUM_PE      = 4,
    parameter int PE_ID_WIDTH = 2,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                         clk,
    input  logic                         reset_poweron,
    input  logic [NUM_PE-1:0]            pe__stu__valid,
    input  logic [2*NUM_PE-1:0]          pe__stu__cntl,
    input  logic [NUM_PE*DATA_WIDTH-1:0] pe__stu__data,
    output logic [NUM_PE-1:0]            stu__pe__ready,
    output logic                         stu__mgr__valid,
    output logic [1:0]                   stu__mgr__cntl,
    output logic [DATA_WIDTH-1:0]        stu__mgr__data,
    output logic [PE_ID_WIDTH-1:0]       stu__mgr__peId,
    input  logic                         mgr__stu__ready,
    output logic                         stu__sys__protocolErr
);

    typedef struct packed {
        logic [1:0]             cntl;
        logic [PE_ID_WIDTH-1:0] pe_id;
        logic [DATA_WIDTH-1:0]  data;
    } beat_t;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state, state_nxt;
    logic [PE_ID_WIDTH-1:0] grant, last_grant, winner, cand, sel;
    logic                   found;
    logic [NUM_PE-1:0]      eligible, stray;
    logic [1:0]             cntl_a [NUM_PE];
    logic [DATA_WIDTH-1:0]  data_a [NUM_PE];

    beat_t                  fifo_mem [2];
    beat_t                  head, push_beat;
    logic                   wr_ptr, rd_ptr;
    logic [1:0]             fifo_cnt;
    logic                   fifo_full, push, pop;
    logic [1:0]             xfer_cntl;

    // Unpack the flat PE buses and qualify each PE's request
    for (genvar i = 0; i < NUM_PE; i++) begin : g_lane
        assign cntl_a[i] = pe__stu__cntl[2*i +: 2];
        assign data_a[i] = pe__stu__data[i*DATA_WIDTH +: DATA_WIDTH];
        pe_array_stu_lane u_lane (
            .valid    (pe__stu__valid[i]),
            .cntl     (cntl_a[i]),
            .eligible (eligible[i]),
            .stray    (stray[i])
        );
    end

    // Round-robin search for the first eligible PE after the last grant
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            cand = PE_ID_WIDTH'((int'(last_grant) + 1 + k) % NUM_PE);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Readiness uses the registered count only, so a full FIFO never
    // sees a push and a pop in the same cycle
    assign fifo_full = (fifo_cnt == 2'd2);
    assign sel       = (state == LOCKED) ? grant : winner;
    assign push      = |(stu__pe__ready & pe__stu__valid);
    assign pop       = stu__mgr__valid & mgr__stu__ready;
    assign xfer_cntl = cntl_a[sel];

    // Arbiter state register
    always_ff @(posedge clk) begin
        if (reset_poweron) state <= IDLE;
        else               state <= state_nxt;
    end

    // Arbiter next state: a start-only beat locks, any end beat unlocks
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (push && !xfer_cntl[1]) state_nxt = LOCKED;
            LOCKED:  if (push &&  xfer_cntl[1]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Arbiter outputs: at most one PE is readied, and only with FIFO room
    always_comb begin
        stu__pe__ready = '0;
        if (!reset_poweron && !fifo_full) begin
            if (state == LOCKED)  stu__pe__ready[grant]  = 1'b1;
            else if (found)       stu__pe__ready[winner] = 1'b1;
        end
    end

    // Grant bookkeeping: remember the packet owner and the last PE served
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            grant      <= '0;
            last_grant <= PE_ID_WIDTH'(NUM_PE - 1);
        end else if (push) begin
            if (state == IDLE) begin
                if (xfer_cntl[1]) last_grant <= winner;
                else              grant      <= winner;
            end else if (xfer_cntl[1]) begin
                last_grant <= grant;
            end
        end
    end

    // Sticky error: a start beat inside an open packet, or a
    // continuation beat offered while no packet is open
    always_ff @(posedge clk) begin
        if (reset_poweron)
            stu__sys__protocolErr <= 1'b0;
        else if ((state == LOCKED && push && xfer_cntl[0]) ||
                 (state == IDLE && |stray))
            stu__sys__protocolErr <= 1'b1;
    end

    // Beat captured into the FIFO comes from the PE currently readied
    always_comb begin
        push_beat       = '0;
        push_beat.cntl  = xfer_cntl;
        push_beat.pe_id = sel;
        push_beat.data  = data_a[sel];
    end

    // Two-entry output FIFO
    always_ff @(posedge clk) begin
        if (reset_poweron) begin
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_beat;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
        end
    end

    assign head            = fifo_mem[rd_ptr];
    assign stu__mgr__valid = (fifo_cnt != 2'd0);
    assign stu__mgr__cntl  = head.cntl;
    assign stu__mgr__peId  = head.pe_id;
    assign stu__mgr__data  = head.data;

endmodule

// File: tb/tb_pe_array_stu_arbiter.sv
// Directed bench for pe_array_stu_arbiter: PE drivers fed from beat
// queues, a packet-level round-robin model producing the expected
// upstream order, and a per-cycle compare process on the STU side.
module tb_pe_array_stu_arbiter;
    localparam int NP = 4;
    localparam int IW = 2;
    localparam int DW = 64;

    logic                 clk = 1'b0;
    logic                 reset_poweron;
    logic [NP-1:0]        pe_valid;
    logic [2*NP-1:0]      pe_cntl;
    logic [NP*DW-1:0]     pe_data;
    logic [NP-1:0]        stu__pe__ready;
    logic                 stu__mgr__valid;
    logic [1:0]           stu__mgr__cntl;
    logic [DW-1:0]        stu__mgr__data;
    logic [IW-1:0]        stu__mgr__peId;
    logic                 mgr__stu__ready;
    logic                 stu__sys__protocolErr;

    pe_array_stu_arbiter #(.NUM_PE(NP), .PE_ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk                   (clk),
        .reset_poweron         (reset_poweron),
        .pe__stu__valid        (pe_valid),
        .pe__stu__cntl         (pe_cntl),
        .pe__stu__data         (pe_data),
        .stu__pe__ready        (stu__pe__ready),
        .stu__mgr__valid       (stu__mgr__valid),
        .stu__mgr__cntl        (stu__mgr__cntl),
        .stu__mgr__data        (stu__mgr__data),
        .stu__mgr__peId        (stu__mgr__peId),
        .mgr__stu__ready       (mgr__stu__ready),
        .stu__sys__protocolErr (stu__sys__protocolErr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_hs_cyc = -1;
    int mdl_last = NP - 1;

    logic [DW+1:0]    peq  [NP][$];   // beats still to be offered by each PE
    logic [DW+1:0]    pend [NP][$];   // model copy of staged packets
    logic [DW+IW+1:0] exp_q [$];      // expected upstream beats {cntl,id,data}
    int               bcyc [$];       // cycle of each delivered beat
    int               bpe  [$];       // source PE of each delivered beat
    logic [DW+IW+1:0] e;
    bit               rdy2_seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // PE drivers: consume a beat on each observed handshake, offer the next
    initial begin : driver
        logic [NP-1:0] hs;
        logic          rs;
        logic [DW+1:0] b;
        pe_valid = '0;
        pe_cntl  = '0;
        pe_data  = '0;
        forever begin
            @(negedge clk);
            hs = pe_valid & stu__pe__ready;
            rs = reset_poweron;
            if (hs != '0 && !rs) last_hs_cyc = cyc;
            @(posedge clk);
            #1;
            for (int i = 0; i < NP; i++) begin
                if (hs[i] && !rs && peq[i].size() > 0) void'(peq[i].pop_front());
                if (peq[i].size() > 0) begin
                    b = peq[i][0];
                    pe_valid[i]           = 1'b1;
                    pe_cntl[2*i +: 2]     = b[DW+1:DW];
                    pe_data[i*DW +: DW]   = b[DW-1:0];
                end else begin
                    pe_valid[i]           = 1'b0;
                    pe_cntl[2*i +: 2]     = 2'b00;
                    pe_data[i*DW +: DW]   = '0;
                end
            end
        end
    end

    // Upstream compare: every delivered beat must be the next expected one
    always @(negedge clk) begin
        if (!reset_poweron) begin
            chk("ready_onehot", ($countones(stu__pe__ready) <= 1), 1);
            if (stu__mgr__valid && mgr__stu__ready) begin
                bcyc.push_back(cyc);
                bpe.push_back(int'(stu__mgr__peId));
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h expected=none",
                             {stu__mgr__cntl, stu__mgr__peId, stu__mgr__data});
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {stu__mgr__cntl, stu__mgr__peId, stu__mgr__data}, e);
                end
            end
        end
    end

    // Stage one packet of n beats for a PE, both to its driver and the model
    task automatic stage_pkt(input int pe, input int n, input logic [DW-1:0] base);
        logic [1:0] c;
        for (int k = 0; k < n; k++) begin
            if (n == 1)          c = 2'b11;
            else if (k == 0)     c = 2'b01;
            else if (k == n - 1) c = 2'b10;
            else                 c = 2'b00;
            peq[pe].push_back({c, base + DW'(k)});
            pend[pe].push_back({c, base + DW'(k)});
        end
    endtask

    // Offer a raw beat and expect it forwarded as-is
    task automatic push_raw(input int pe, input logic [1:0] c, input logic [DW-1:0] d);
        peq[pe].push_back({c, d});
        exp_q.push_back({c, IW'(pe), d});
    endtask

    // Packet-level round robin over all staged packets
    task automatic run_model();
        bit            any;
        int            p;
        logic [DW+1:0] b;
        do begin
            any = 1'b0;
            for (int s = 1; s <= NP; s++) begin
                p = (mdl_last + s) % NP;
                if (pend[p].size() > 0) begin
                    any = 1'b1;
                    do begin
                        b = pend[p].pop_front();
                        exp_q.push_back({b[DW+1:DW], IW'(p), b[DW-1:0]});
                    end while (!b[DW+1] && pend[p].size() > 0);
                    mdl_last = p;
                    break;
                end
            end
        end while (any);
    endtask

    function automatic bit pe_busy();
        bit r = 1'b0;
        for (int i = 0; i < NP; i++) if (peq[i].size() > 0) r = 1'b1;
        return r;
    endfunction

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        bit busy = 1'b1;
        while (busy && n < budget) begin
            tick();
            n++;
            busy = (exp_q.size() > 0) || pe_busy() || stu__mgr__valid;
        end
        chk({tag, "_drained"}, busy, 0);
    endtask

    task automatic reset_pulse(input int n);
        reset_poweron = 1'b1;
        for (int i = 0; i < NP; i++) begin
            peq[i].delete();
            pend[i].delete();
        end
        exp_q.delete();
        mdl_last = NP - 1;
        repeat (n) tick();
        reset_poweron = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mgr_valid"}, stu__mgr__valid, 0);
        chk({tag, "_mgr_cntl"},  stu__mgr__cntl, 0);
        chk({tag, "_mgr_data"},  stu__mgr__data, 0);
        chk({tag, "_mgr_peid"},  stu__mgr__peId, 0);
        chk({tag, "_pe_ready"},  stu__pe__ready, 0);
        chk({tag, "_err"},       stu__sys__protocolErr, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : test
        reset_poweron   = 1'b1;
        mgr__stu__ready = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("rst_in");
        reset_poweron = 1'b0;
        tick();
        chk_reset_outputs("rst_idle");

        // Single-beat packet from PE2
        bcyc.delete(); bpe.delete();
        stage_pkt(2, 1, 64'hA5);
        run_model();
        tick();
        chk("t1_ready2", stu__pe__ready, 4'b0100);
        wait_drain(20, "t1");
        chk("t1_nbeats", bcyc.size(), 1);
        chk("t1_latency", bcyc[0], last_hs_cyc + 1);
        chk("t1_peid", bpe[0], 2);
        chk("t1_no_ready_after", stu__pe__ready, 0);

        // All four PEs, 3-beat packets, simultaneously after reset
        reset_pulse(2);
        bcyc.delete(); bpe.delete();
        for (int p = 0; p < NP; p++) stage_pkt(p, 3, DW'(32'h100 * (p + 1)));
        run_model();
        wait_drain(100, "t2");
        chk("t2_nbeats", bcyc.size(), 12);
        chk("t2_span", bcyc[11] - bcyc[0], 11);
        for (int k = 0; k < NP; k++) chk("t2_order", bpe[3*k], k);

        // PE1/PE3 contention, a lone PE1 packet, then contention again
        bcyc.delete(); bpe.delete();
        stage_pkt(1, 2, 64'h1100);
        stage_pkt(3, 2, 64'h3300);
        run_model();
        wait_drain(50, "t3a");
        chk("t3a_first", bpe[0], 1);
        chk("t3a_second", bpe[2], 3);
        stage_pkt(1, 1, 64'h1111);
        run_model();
        wait_drain(50, "t3b");
        bcyc.delete(); bpe.delete();
        stage_pkt(1, 2, 64'h1200);
        stage_pkt(3, 2, 64'h3200);
        run_model();
        wait_drain(50, "t3c");
        chk("t3c_first", bpe[0], 3);
        chk("t3c_second", bpe[2], 1);

        // Manager stall: only two beats may be buffered
        bcyc.delete(); bpe.delete();
        mgr__stu__ready = 1'b0;
        stage_pkt(0, 4, 64'h4000);
        run_model();
        repeat (5) tick();
        chk("t4_pe_left", peq[0].size(), 2);
        chk("t4_ready0_stall", stu__pe__ready[0], 0);
        chk("t4_mgr_valid", stu__mgr__valid, 1);
        chk("t4_no_delivery", bcyc.size(), 0);
        mgr__stu__ready = 1'b1;
        wait_drain(50, "t4");
        chk("t4_nbeats", bcyc.size(), 4);

        // SOM inside an open packet: flagged and forwarded
        bcyc.delete(); bpe.delete();
        push_raw(1, 2'b01, 64'h51);
        push_raw(1, 2'b01, 64'h52);
        push_raw(1, 2'b10, 64'h53);
        wait_drain(30, "t5a");
        chk("t5a_nbeats", bcyc.size(), 3);
        chk("t5a_err", stu__sys__protocolErr, 1);
        reset_pulse(1);
        tick();
        chk("t5_err_cleared", stu__sys__protocolErr, 0);

        // Stray MOM from PE2 with no packet open
        bcyc.delete(); bpe.delete();
        rdy2_seen = 1'b0;
        peq[2].push_back({2'b00, 64'h77});
        for (int k = 0; k < 5; k++) begin
            tick();
            if (stu__pe__ready[2]) rdy2_seen = 1'b1;
        end
        chk("t5b_ready2_never", rdy2_seen, 0);
        chk("t5b_err", stu__sys__protocolErr, 1);
        chk("t5b_no_beats", bcyc.size(), 0);
        reset_pulse(1);

        // Reset in the middle of a PE3 packet
        tick();
        bcyc.delete(); bpe.delete();
        stage_pkt(3, 4, 64'h300);
        run_model();
        repeat (3) tick();
        chk("t6_taken", peq[3].size(), 2);
        chk("t6_delivered", bcyc.size(), 1);
        reset_pulse(1);
        chk_reset_outputs("t6_rst");
        bcyc.delete(); bpe.delete();
        stage_pkt(3, 1, 64'h3E);
        stage_pkt(0, 1, 64'h0E);
        run_model();
        wait_drain(30, "t6");
        chk("t6_first_pe0", bpe[0], 0);
        chk("t6_nbeats", bcyc.size(), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
